// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg
//   Shared types and constants for the HC-SR04 ranging controller.
//   - state_e    : controller state encoding
//   - result_t   : published measurement (timeout flag + echo width in us)
//   - CNT_W      : width of every counter in the design
//   - cyc_per_us : clock cycles per microsecond for a given clock frequency
//   - sat_inc    : saturating counter increment
package hcsr04_pkg;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4,
        ST_HOLDOFF   = 3'd5
    } state_e;

    typedef struct packed {
        logic timeout;
        cnt_t echo_us;
    } result_t;

    // The clock frequency must be an integer multiple of 1 MHz.
    function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Cycles per microsecond at the default 50 MHz system clock.
    localparam int unsigned CYC_PER_US = cyc_per_us(50_000_000);

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic cnt_t sat_inc(input cnt_t v, input logic inc);
        if (inc && (v != '1)) begin
            return v + cnt_t'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/hcsr04_ctrl_us_tick_gen.sv
// us_tick_gen
//   Microsecond prescaler. Counts 0..DIV-1 and raises tick for exactly
//   one cycle at the terminal count. clr restarts the count from 0 on
//   the next cycle, so a fresh microsecond starts with every state entry.
//   Ports:
//     clk   in  system clock
//     rst_n in  synchronous active-low reset
//     clr   in  synchronous prescaler clear
//     tick  out one-cycle pulse once per microsecond
module us_tick_gen
    import hcsr04_pkg::*;
#(
    parameter int unsigned DIV = CYC_PER_US
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // NOTE: every variable assigned in always_comb gets a default at the
    // top of the block, so no path can leave it unassigned (no latch).
    always_comb begin
        tick  = (pre_q == TERM);
        pre_d = pre_q + PW'(1);
        if (tick || clr) begin
            pre_d = '0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking (<=)
    // assignments, so all flops sample their inputs on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/hcsr04_ctrl.sv
// hcsr04_ctrl
//   Runs one HC-SR04 ranging cycle: trigger pulse, wait for echo rise,
//   measure echo high time in microseconds, publish the result with a
//   one-cycle valid strobe, then hold off until the measurement period
//   has elapsed. Repeats while en is high; start requests a single shot.
//   Ports:
//     clk     in   system clock
//     rst_n   in   synchronous active-low reset
//     en      in   periodic mode enable
//     start   in   single-shot request (pulse), honoured only in IDLE
//     echo    in   asynchronous sensor echo pin
//     trig    out  sensor trigger pin
//     busy    out  high in every state except IDLE
//     echo_us out  last echo width in us, held until the next result
//     valid   out  one-cycle strobe: echo_us/timeout just updated
//     timeout out  qualifies valid: the measurement failed
module hcsr04_ctrl
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned RISE_TO_US  = 1000,
    parameter int unsigned ECHO_MAX_US = 30000,
    parameter int unsigned PERIOD_US   = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [CNT_W-1:0] echo_us,
    output logic             valid,
    output logic             timeout
);

    localparam int unsigned CYC = cyc_per_us(CLK_HZ);

    localparam cnt_t TRIG_LIM = cnt_t'(TRIG_US);
    localparam cnt_t RISE_LIM = cnt_t'(RISE_TO_US);
    localparam cnt_t MAX_LIM  = cnt_t'(ECHO_MAX_US);
    // The period counter runs in clock cycles. HOLDOFF leaves two cycles
    // early so that the IDLE cycle plus the next TRIG entry land exactly
    // one period after the previous TRIG entry.
    localparam cnt_t PERIOD_EXIT = cnt_t'(PERIOD_US * CYC - 2);

    state_e  state_q, state_d;
    cnt_t    us_cnt_q, us_cnt_d, us_cnt_inc;
    cnt_t    period_cnt_q, period_cnt_d;
    result_t res_q, res_d;
    logic    echo_s1_q, echo_s2_q, echo_s3_q;
    logic    echo_rise, echo_fall;
    logic    state_entry, trig_entry;
    logic    tick;

    // ------------------------------------------------------------------
    // Echo synchronizer and edge detect. s1/s2 resynchronize the pin, s3
    // is the delayed copy the edges are taken against.
    // ------------------------------------------------------------------
    // NOTE: the synchronizer flops are reset along with the rest of the
    // design so a stale high echo cannot produce a false edge afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            echo_s3_q <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
        end
    end

    assign echo_rise = echo_s2_q & ~echo_s3_q;
    assign echo_fall = ~echo_s2_q & echo_s3_q;

    // ------------------------------------------------------------------
    // Microsecond timebase, restarted on every state entry.
    // ------------------------------------------------------------------
    us_tick_gen #(
        .DIV (CYC)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_entry),
        .tick  (tick)
    );

    // Count including the current cycle's tick: a limit is acted on in
    // the same cycle the count reaches it.
    assign us_cnt_inc = sat_inc(us_cnt_q, tick);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Edge checks come before limit checks so a
    // rise beats the rise timeout and a fall beats the echo maximum.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start || en) begin
                    state_d = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (us_cnt_inc >= TRIG_LIM) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                end else if (us_cnt_inc >= RISE_LIM) begin
                    state_d = ST_DONE;
                end
            end
            ST_MEASURE: begin
                if (echo_fall || (us_cnt_inc >= MAX_LIM)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (period_cnt_q >= PERIOD_EXIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        trig    = (state_q == ST_TRIG);
        busy    = (state_q != ST_IDLE);
        valid   = (state_q == ST_DONE);
        echo_us = res_q.echo_us;
        timeout = res_q.timeout;
    end

    // ------------------------------------------------------------------
    // Datapath: state counter, period counter, published result
    // ------------------------------------------------------------------
    always_comb begin
        state_entry  = (state_d != state_q);
        trig_entry   = (state_d == ST_TRIG) && (state_q != ST_TRIG);

        us_cnt_d     = state_entry ? '0 : us_cnt_inc;
        period_cnt_d = trig_entry ? '0 : sat_inc(period_cnt_q, 1'b1);

        // The result only moves on the transition into DONE, so it
        // becomes visible together with valid.
        res_d = res_q;
        if ((state_q == ST_WAIT_RISE) && (state_d == ST_DONE)) begin
            res_d.timeout = 1'b1;
        end
        if ((state_q == ST_MEASURE) && (state_d == ST_DONE)) begin
            if (echo_fall) begin
                res_d.timeout = 1'b0;
                res_d.echo_us = us_cnt_inc;
            end else begin
                res_d.timeout = 1'b1;
                res_d.echo_us = MAX_LIM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            us_cnt_q     <= '0;
            period_cnt_q <= '0;
            res_q        <= '0;
        end else begin
            us_cnt_q     <= us_cnt_d;
            period_cnt_q <= period_cnt_d;
            res_q        <= res_d;
        end
    end

endmodule

// File: tb/tb_hcsr04_ctrl.sv
// tb_hcsr04_ctrl
//   Directed bench for hcsr04_ctrl at a 4 MHz clock (4 cycles per us).
//   Expected values are hand-computed from the parameters below.
module tb_hcsr04_ctrl;

    localparam int unsigned CLK_HZ      = 4_000_000;
    localparam int unsigned TRIG_US     = 10;
    localparam int unsigned RISE_TO_US  = 50;
    localparam int unsigned ECHO_MAX_US = 500;
    localparam int unsigned PERIOD_US   = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic        busy;
    logic [31:0] echo_us;
    logic        valid;
    logic        timeout;

    hcsr04_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .TRIG_US     (TRIG_US),
        .RISE_TO_US  (RISE_TO_US),
        .ECHO_MAX_US (ECHO_MAX_US),
        .PERIOD_US   (PERIOD_US)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (start),
        .echo    (echo),
        .trig    (trig),
        .busy    (busy),
        .echo_us (echo_us),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns exp when got lies within +/-1 of it, otherwise got itself.
    function automatic logic [31:0] near(input logic [31:0] got, input logic [31:0] exp);
        if ((got + 32'd1 >= exp) && (got <= exp + 32'd1)) begin
            return exp;
        end
        return got;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: cycle stamps for trig edges and valid strobes, sampled on
    // the falling edge.
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          valid_cnt = 0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          last_rise = 0;
    int          prev_rise = 0;
    int          fall_cyc = 0;
    int          v_cyc = 0;
    logic [31:0] v_echo = '0;
    logic        v_to = 1'b0;
    logic        trig_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            v_cyc  = cyc;
            v_echo = echo_us;
            v_to   = timeout;
        end
        if (trig && !trig_prev) begin
            rise_cnt++;
            prev_rise = last_rise;
            last_rise = cyc;
        end
        if (!trig && trig_prev) begin
            fall_cnt++;
            fall_cyc = cyc;
        end
        trig_prev = trig;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; all return 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_fall(input string tag, input int max_cyc);
        int base = fall_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk);
            if (fall_cnt != base) seen = 1'b1;
        end
        #1;
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int base = valid_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk);
            if (valid_cnt != base) seen = 1'b1;
        end
        #1;
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step(1);
            if (!busy) seen = 1'b1;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vbase;
        int rbase;
        int rise_drv;

        // ---------------- reset ----------------
        step(3);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_echo_us", echo_us, 32'd0);
        rst_n = 1'b1;
        step(2);

        // ---------------- normal 290 us echo ----------------
        vbase = valid_cnt;
        pulse_start();
        wait_fall("m1_trig_fall_wait", 200);
        check("m1_trig_width", 32'(fall_cyc - last_rise), 32'd40);
        step(80);
        echo = 1'b1;
        step(1160);
        echo = 1'b0;
        wait_valid("m1_valid_wait", 50);
        check("m1_echo_us", near(v_echo, 32'd290), 32'd290);
        check("m1_timeout", 32'(v_to), 32'd0);
        wait_idle("m1_idle_wait", 5000);
        check("m1_valid_once", 32'(valid_cnt - vbase), 32'd1);

        // ---------------- no echo: rise timeout ----------------
        pulse_start();
        wait_fall("m2_trig_fall_wait", 200);
        wait_valid("m2_valid_wait", 400);
        check("m2_valid_delay", 32'(v_cyc - fall_cyc), 32'd200);
        check("m2_timeout", 32'(v_to), 32'd1);
        check("m2_echo_us_held", near(v_echo, 32'd290), 32'd290);
        wait_idle("m2_idle_wait", 5000);

        // ---------------- echo too long: max timeout ----------------
        pulse_start();
        wait_fall("m3_trig_fall_wait", 200);
        step(40);
        echo = 1'b1;
        rise_drv = cyc;
        wait_valid("m3_valid_wait", 2500);
        check("m3_timeout", 32'(v_to), 32'd1);
        check("m3_echo_us", v_echo, 32'd500);
        // 3 cycles of input latency plus 2000 cycles of measurement
        check("m3_valid_delay", near(32'(v_cyc - rise_drv), 32'd2003), 32'd2003);
        step(2400 - (cyc - rise_drv));
        echo = 1'b0;
        wait_idle("m3_idle_wait", 5000);

        // ---------------- periodic mode ----------------
        vbase = valid_cnt;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_fall("per_trig_fall_wait", 5000);
            if (k > 0) check("per_spacing", 32'(last_rise - prev_rise), 32'd4000);
            step(20);
            echo = 1'b1;
            step(400);
            echo = 1'b0;
            wait_valid("per_valid_wait", 50);
            check("per_echo_us", near(v_echo, 32'd100), 32'd100);
            check("per_timeout", 32'(v_to), 32'd0);
        end
        en = 1'b0;
        rbase = rise_cnt;
        wait_idle("per_idle_wait", 5000);
        step(100);
        check("per_stop_no_trig", 32'(rise_cnt - rbase), 32'd0);
        check("per_valid_count", 32'(valid_cnt - vbase), 32'd3);

        // ---------------- reset during MEASURE ----------------
        vbase = valid_cnt;
        pulse_start();
        wait_fall("rm_trig_fall_wait", 200);
        step(20);
        echo = 1'b1;
        step(100);
        check("rm_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step(1);
        check("rm_trig", 32'(trig), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_valid", 32'(valid), 32'd0);
        check("rm_echo_us", echo_us, 32'd0);
        rst_n = 1'b1;
        echo  = 1'b0;
        step(50);
        check("rm_no_valid", 32'(valid_cnt - vbase), 32'd0);

        // ------- measure after reset; extra starts while busy -------
        vbase = valid_cnt;
        rbase = rise_cnt;
        pulse_start();
        wait_fall("sb_trig_fall_wait", 200);
        pulse_start();
        step(20);
        echo = 1'b1;
        step(200);
        echo = 1'b0;
        wait_valid("sb_valid_wait", 50);
        check("sb_echo_us", near(v_echo, 32'd50), 32'd50);
        check("sb_timeout", 32'(v_to), 32'd0);
        step(10);
        pulse_start();
        wait_idle("sb_idle_wait", 5000);
        step(100);
        check("sb_one_trig", 32'(rise_cnt - rbase), 32'd1);
        check("sb_one_valid", 32'(valid_cnt - vbase), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
